// File: rtl/bcd_ser2par.sv
// bcd_ser2par: assembles LSB-first serial BCD digits and queues them in a small FIFO.
// Define BCD_ERR_CHECK_EN to drop non-BCD codes (1010-1111) and flag them on err_o.
module bcd_ser2par #(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ser_valid_i,
    input  logic       ser_bit_i,
    input  logic       ser_sof_i,
    output logic       ser_ready_o,
    output logic [3:0] bcd_o4,
    output logic       bcd_valid_o,
    input  logic       bcd_ready_i,
    output logic       err_o
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]  r_bit_cnt;
    logic [3:0]  r_shift;
    logic [3:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_err;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_resync;
    logic        w_last;
    logic        w_bad_code;
    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_digit;
    logic [AW:0] w_ptr_one;

    assign w_ptr_one = {{AW{1'b0}}, 1'b1};

    assign w_full  = (r_wptr[AW] != r_rptr[AW])
                  && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    // Readiness depends only on registered pointers: no bypass from bcd_ready_i.
    assign w_accept = ser_valid_i & ~w_full;
    assign w_resync = w_accept & ser_sof_i & (r_bit_cnt != 2'd0);
    assign w_last   = w_accept & ~ser_sof_i & (r_bit_cnt == 2'd3);
    assign w_digit  = {ser_bit_i, r_shift[2:0]};

`ifdef BCD_ERR_CHECK_EN
    assign w_bad_code = w_last & (w_digit > 4'd9);
`else
    assign w_bad_code = 1'b0;
`endif

    assign w_push = w_last & ~w_bad_code;
    assign w_pop  = ~w_empty & bcd_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt <= 2'd0;
            r_shift   <= 4'h0;
        end else if (w_accept) begin
            if (ser_sof_i) begin
                r_shift   <= {3'b000, ser_bit_i};
                r_bit_cnt <= 2'd1;
            end else begin
                r_shift[r_bit_cnt] <= ser_bit_i;
                r_bit_cnt          <= r_bit_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_resync | w_bad_code;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + w_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + w_ptr_one;
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_digit;
        end
    end

    assign ser_ready_o = ~w_full;
    assign bcd_valid_o = ~w_empty;
    assign bcd_o4      = w_empty ? 4'h0 : r_mem[r_rptr[AW-1:0]];
    assign err_o       = r_err;
endmodule

// File: tb/tb_bcd_ser2par.sv
// tb_bcd_ser2par: directed scoreboard bench for bcd_ser2par (DEPTH=2).
// Honours BCD_ERR_CHECK_EN when computing expected digits and error pulses.
module tb_bcd_ser2par;
    localparam int DEPTH = 2;
`ifdef BCD_ERR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       ser_valid_i;
    logic       ser_bit_i;
    logic       ser_sof_i;
    logic       ser_ready_o;
    logic [3:0] bcd_o4;
    logic       bcd_valid_o;
    logic       bcd_ready_i;
    logic       err_o;

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_err = 0;
    int         exp_err = 0;
    int         err_mark;
    logic [3:0] exp_q [$];
    logic [3:0] exp_d;

    bcd_ser2par #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ser_valid_i (ser_valid_i),
        .ser_bit_i   (ser_bit_i),
        .ser_sof_i   (ser_sof_i),
        .ser_ready_o (ser_ready_o),
        .bcd_o4      (bcd_o4),
        .bcd_valid_o (bcd_valid_o),
        .bcd_ready_i (bcd_ready_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every consumed digit is checked against the scoreboard.
    always @(negedge clk_i) begin
        if (err_o === 1'b1) n_err++;
        if (bcd_valid_o === 1'b1 && bcd_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL unexpected_digit observed=%0h expected=none", bcd_o4);
                end
            end else begin
                exp_d = exp_q.pop_front();
                chk("digit", {28'd0, bcd_o4}, {28'd0, exp_d});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_bit(input logic b, input logic sof);
        int waited;
        waited = 0;
        ser_valid_i = 1'b1;
        ser_bit_i   = b;
        ser_sof_i   = sof;
        @(negedge clk_i);
        while (ser_ready_o !== 1'b1 && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        if (ser_ready_o !== 1'b1) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk_i);
        #1;
        ser_valid_i = 1'b0;
        ser_sof_i   = 1'b0;
        ser_bit_i   = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] v, input logic sof,
                              input logic push);
        send_bit(v[0], sof);
        send_bit(v[1], 1'b0);
        send_bit(v[2], 1'b0);
        if (push) exp_q.push_back(v);
        send_bit(v[3], 1'b0);
    endtask

    initial begin
        rst_i       = 1'b1;
        ser_valid_i = 1'b0;
        ser_bit_i   = 1'b0;
        ser_sof_i   = 1'b0;
        bcd_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", {31'd0, ser_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, bcd_valid_o}, 32'd0);
        chk("rst_err",   {31'd0, err_o},       32'd0);
        chk("rst_bcd",   {28'd0, bcd_o4},      32'd0);
        rst_i = 1'b0;

        // Digit 9, single-cycle presentation after the 4th accept
        send_digit(4'h9, 1'b1, 1'b1);
        chk("d9_valid", {31'd0, bcd_valid_o}, 32'd1);
        chk("d9_value", {28'd0, bcd_o4},      32'h9);
        @(posedge clk_i);
        #1;
        chk("d9_gone", {31'd0, bcd_valid_o}, 32'd0);

        // Back-pressure: 3 and 7 fill the FIFO
        bcd_ready_i = 1'b0;
        send_digit(4'h3, 1'b1, 1'b1);
        send_digit(4'h7, 1'b1, 1'b1);
        chk("full_ready", {31'd0, ser_ready_o}, 32'd0);
        chk("full_valid", {31'd0, bcd_valid_o}, 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        chk("hold_bcd", {28'd0, bcd_o4}, 32'h3);
        bcd_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("drain_ready", {31'd0, ser_ready_o}, 32'd1);
        chk("drain_valid", {31'd0, bcd_valid_o}, 32'd0);
        chk("drain_q", exp_q.size(), 32'd0);

        // Resync: sof mid-digit discards the partial digit
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        exp_err++;
        chk("resync_err", {31'd0, err_o}, 32'd1);
        @(posedge clk_i);
        #1;
        chk("resync_err_end", {31'd0, err_o}, 32'd0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        exp_q.push_back(4'h2);
        send_bit(1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("resync_q", exp_q.size(), 32'd0);

        // Non-BCD code 12 followed by 5
        send_digit(4'hC, 1'b1, !CHK);
        if (CHK) exp_err++;
        send_digit(4'h5, 1'b1, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        chk("code12_err", n_err, exp_err);
        chk("code12_q", exp_q.size(), 32'd0);

        // Simultaneous pop and bit attempt while full
        bcd_ready_i = 1'b0;
        send_digit(4'h1, 1'b1, 1'b1);
        send_digit(4'h2, 1'b1, 1'b1);
        err_mark    = n_err;
        bcd_ready_i = 1'b1;
        ser_valid_i = 1'b1;
        ser_bit_i   = 1'b1;
        ser_sof_i   = 1'b1;
        @(negedge clk_i);
        chk("no_bypass", {31'd0, ser_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        send_digit(4'h3, 1'b1, 1'b1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("pop_push_q", exp_q.size(), 32'd0);
        chk("pop_push_err", n_err - err_mark, 32'd0);

        // Asynchronous reset with one digit buffered and two bits pending
        bcd_ready_i = 1'b0;
        send_digit(4'h4, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        err_mark = n_err;
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bcd_valid_o}, 32'd0);
        chk("arst_ready", {31'd0, ser_ready_o}, 32'd1);
        chk("arst_bcd",   {28'd0, bcd_o4},      32'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        bcd_ready_i = 1'b1;
        send_digit(4'h5, 1'b0, 1'b1);
        chk("fresh_value", {28'd0, bcd_o4}, 32'h5);
        repeat (3) @(posedge clk_i);
        #1;
        chk("fresh_q", exp_q.size(), 32'd0);
        chk("arst_no_err", n_err - err_mark, 32'd0);
        chk("total_err", n_err, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_ser2par.md
BCD_SER2PAR -- requirements
Module: bcd_ser2par

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output FIFO depth in digits, a power of two, minimum 2.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ser_valid_i, input, 1, a serial bit is presented.
REQ-005 SHALL have port ser_bit_i, input, 1, serial data, LSB first (z, y, x, w).
REQ-006 SHALL have port ser_sof_i, input, 1, marks the presented bit as bit 0 of a new digit.
REQ-007 SHALL have port ser_ready_o, output, 1, the block accepts a bit when ser_valid_i and ser_ready_o are both high.
REQ-008 SHALL have port bcd_o4, output, 4, head-of-FIFO BCD digit ([3]=w ... [0]=z), feeding the BCD-to-Excess-3 stage.
REQ-009 SHALL have port bcd_valid_o, output, 1, bcd_o4 holds a digit.
REQ-010 SHALL have port bcd_ready_i, input, 1, downstream consumes the digit when bcd_valid_o and bcd_ready_i are both high.
REQ-011 SHALL have port err_o, output, 1, one-cycle error pulse.

Function
REQ-012 SHALL shift accepted bits into a 4-bit register at position bit_cnt, with a 2-bit counter bit_cnt (0..3) advancing per accepted bit and wrapping 3->0.
REQ-013 SHALL, on an accepted bit with ser_sof_i=1, store the bit at position 0 and set bit_cnt to 1 regardless of the current count.
REQ-014 SHALL, if ser_sof_i arrives while bit_cnt!=0, discard the partial digit and pulse err_o in the next cycle.
REQ-015 SHALL, on acceptance of the 4th bit (bit_cnt=3), write the assembled digit into the FIFO at that edge, so bcd_valid_o rises 1 cycle after the accepting edge when the FIFO was empty.
REQ-016 SHALL drive ser_ready_o = ~full, computed from registered FIFO state only, with no combinational path from bcd_ready_i.
REQ-017 SHALL, when a FIFO push and pop occur on the same edge while full, still deassert ser_ready_o for that cycle (no bypass), so no digit is ever lost.
REQ-018 SHALL pop the FIFO on bcd_valid_o & bcd_ready_i and present the next entry on the following cycle.
REQ-019 SHALL hold bcd_o4 stable while bcd_valid_o=1 and bcd_ready_i=0.
REQ-020 SHALL implement the FIFO with wrapping read/write pointers of log2(DEPTH)+1 bits, with full when the MSBs differ and the rest are equal, and empty when all bits are equal.
REQ-021 SHALL ignore ser_bit_i and ser_sof_i when ser_valid_i=0 or ser_ready_o=0.

Reset
REQ-022 SHALL, on rst_i asserted, immediately clear bit_cnt, the shift register, and the FIFO pointers, and drive bcd_valid_o=0, err_o=0, ser_ready_o=1, and bcd_o4=4'h0.
REQ-023 SHALL lose any partial digit and all buffered digits on reset mid-operation, with no err_o pulse.
REQ-024 SHALL accept the first bit on the first rising edge after rst_i deasserts.

Configuration
REQ-025 SHALL, with BCD_ERR_CHECK_EN defined, drop assembled codes 1010-1111 (not written to the FIFO) and pulse err_o one cycle after the 4th-bit edge.
REQ-026 SHALL, without BCD_ERR_CHECK_EN, write all 16 codes to the FIFO, with err_o driven only by the REQ-014 condition.

Verification
REQ-027 SHALL pass this scenario: reset, then bits 1,0,0,1 (sof on the first) with bcd_ready_i=1 -> bcd_o4=4'h9 and bcd_valid_o=1 exactly 1 cycle after the 4th accept, for one cycle.
REQ-028 SHALL pass this scenario: bcd_ready_i=0, DEPTH=2, send digits 3 then 7 -> ser_ready_o=0 after the 2nd digit; raise bcd_ready_i -> 3 then 7 in order, and ser_ready_o returns to 1.
REQ-029 SHALL pass this scenario: bits 1,1 then sof with bit 0, then 1,0,0 -> err_o pulses once, and a single digit 4'h2 is output.
REQ-030 SHALL pass this scenario: with BCD_ERR_CHECK_EN, send 1100 (value 12) then 0101 -> err_o pulses once, and only 4'h5 is output; without the macro, 4'hC then 4'h5 are output.
REQ-031 SHALL pass this scenario: full FIFO with a simultaneous pop and 4th-bit attempt -> the bit is not accepted that cycle and is accepted on the next cycle, with no digit lost or duplicated.
REQ-032 SHALL pass this scenario: assert rst_i asynchronously after 2 bits with 1 digit buffered -> bcd_valid_o falls before the next clock edge, and the next 4 bits form a fresh digit.
